// File: rtl/arbi_rr.sv
// N-channel arbiter feeding one registered valid/ready output stage.
// Round-robin or fixed-priority selection; last winner is masked for one edge.
module arbi_rr #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 8,
  parameter int RR_MODE = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          req,
  input  logic [NUM_CH*DATA_W-1:0]   data_in,
  output logic [NUM_CH-1:0]          grant,
  output logic [$clog2(NUM_CH)-1:0]  grant_id,
  output logic [DATA_W-1:0]          arb_out,
  output logic                       out_valid,
  input  logic                       out_ready
);

  localparam int ID_W = $clog2(NUM_CH);

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   start;
  logic [ID_W-1:0]   winner;
  logic [ID_W:0]     idx;
  logic              found;
  logic              load;
  logic [NUM_CH-1:0] eligible;
  logic [NUM_CH-1:0] win_onehot;
  logic [DATA_W-1:0] win_data;

  // Fixed priority reuses the wrapping search by pinning the start just below channel 0.
  always_comb begin
    load     = !out_valid || out_ready;
    eligible = req & ~grant;
    start    = (RR_MODE != 0) ? ptr : ID_W'(NUM_CH - 1);
    winner   = '0;
    found    = 1'b0;
    idx      = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = {1'b0, start} + (ID_W+1)'(k + 1);
      if (idx >= (ID_W+1)'(NUM_CH))
        idx = idx - (ID_W+1)'(NUM_CH);
      if (!found && eligible[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
    win_onehot = NUM_CH'(1) << winner;
    win_data   = data_in[int'(winner)*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      arb_out   <= '0;
      out_valid <= 1'b0;
      grant     <= '0;
      grant_id  <= '0;
      ptr       <= ID_W'(NUM_CH - 1);
    end else if (load) begin
      if (found) begin
        arb_out   <= win_data;
        out_valid <= 1'b1;
        grant     <= win_onehot;
        grant_id  <= winner;
        ptr       <= winner;
      end else begin
        out_valid <= 1'b0;
        grant     <= '0;
      end
    end else begin
      grant <= '0;
    end
  end

endmodule

// File: tb/tb_arbi_rr.sv
// Directed bench for arbi_rr: a round-robin and a fixed-priority instance
// share clock, reset and inputs; expected values are hand-computed.
module tb_arbi_rr;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic        out_ready;

  logic [3:0]  rr_grant, fx_grant;
  logic [1:0]  rr_grant_id, fx_grant_id;
  logic [7:0]  rr_arb_out, fx_arb_out;
  logic        rr_out_valid, fx_out_valid;

  int test_count = 0;
  int fail_count = 0;

  logic [7:0] exp_rr_data  [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
  logic [3:0] exp_rr_grant [5] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1};
  logic [7:0] exp_fx_data  [5] = '{8'h10, 8'h11, 8'h10, 8'h11, 8'h10};
  logic [3:0] exp_fx_grant [5] = '{4'h1, 4'h2, 4'h1, 4'h2, 4'h1};

  arbi_rr #(.NUM_CH(4), .DATA_W(8), .RR_MODE(1)) dut_rr (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .grant(rr_grant), .grant_id(rr_grant_id), .arb_out(rr_arb_out),
    .out_valid(rr_out_valid), .out_ready(out_ready)
  );

  arbi_rr #(.NUM_CH(4), .DATA_W(8), .RR_MODE(0)) dut_fx (
    .clk(clk), .reset(reset), .req(req), .data_in(data_in),
    .grant(fx_grant), .grant_id(fx_grant_id), .arb_out(fx_arb_out),
    .out_valid(fx_out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] d, input logic rdy);
    req       = r;
    data_in   = d;
    out_ready = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state before any clock edge
    reset = 1'b0;
    applyStimulus(4'hF, 32'h13121110, 1'b1);
    #2;
    checkOutput("reset_arb_out", 32'(rr_arb_out), 32'h0);
    checkOutput("reset_valid", 32'(rr_out_valid), 32'h0);
    checkOutput("reset_grant", 32'(rr_grant), 32'h0);
    checkOutput("reset_grant_id", 32'(rr_grant_id), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // All requests held, consumer always ready
    for (int i = 0; i < 5; i++) begin
      step();
      checkOutput($sformatf("rr_all_data_%0d", i), 32'(rr_arb_out), 32'(exp_rr_data[i]));
      checkOutput($sformatf("rr_all_grant_%0d", i), 32'(rr_grant), 32'(exp_rr_grant[i]));
      checkOutput($sformatf("rr_all_valid_%0d", i), 32'(rr_out_valid), 32'h1);
      checkOutput($sformatf("fx_all_data_%0d", i), 32'(fx_arb_out), 32'(exp_fx_data[i]));
      checkOutput($sformatf("fx_all_grant_%0d", i), 32'(fx_grant), 32'(exp_fx_grant[i]));
    end

    // Backpressure after the first capture
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    step();
    checkOutput("bp_first_data", 32'(rr_arb_out), 32'h10);
    checkOutput("bp_first_grant", 32'(rr_grant), 32'h1);
    applyStimulus(4'hF, 32'h13121110, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput($sformatf("bp_hold_data_%0d", i), 32'(rr_arb_out), 32'h10);
      checkOutput($sformatf("bp_hold_valid_%0d", i), 32'(rr_out_valid), 32'h1);
      checkOutput($sformatf("bp_hold_grant_%0d", i), 32'(rr_grant), 32'h0);
    end
    applyStimulus(4'hF, 32'h13121110, 1'b1);
    step();
    checkOutput("bp_rel_data_0", 32'(rr_arb_out), 32'h11);
    checkOutput("bp_rel_grant_0", 32'(rr_grant), 32'h2);
    step();
    checkOutput("bp_rel_data_1", 32'(rr_arb_out), 32'h12);
    checkOutput("bp_rel_grant_1", 32'(rr_grant), 32'h4);
    checkOutput("bp_rel_valid_1", 32'(rr_out_valid), 32'h1);

    // Reset mid-stream clears outputs without a clock edge
    #3;
    reset = 1'b0;
    #1;
    checkOutput("mid_reset_arb_out", 32'(rr_arb_out), 32'h0);
    checkOutput("mid_reset_valid", 32'(rr_out_valid), 32'h0);
    checkOutput("mid_reset_grant", 32'(rr_grant), 32'h0);
    checkOutput("mid_reset_grant_id", 32'(rr_grant_id), 32'h0);
    step();
    checkOutput("held_reset_grant", 32'(rr_grant), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step();
    checkOutput("post_reset_data", 32'(rr_arb_out), 32'h10);
    checkOutput("post_reset_grant", 32'(rr_grant), 32'h1);

    // Single requester on channel 2
    applyStimulus(4'h4, 32'h135A1110, 1'b1);
    step();
    checkOutput("solo_grant_0", 32'(rr_grant), 32'h4);
    checkOutput("solo_valid_0", 32'(rr_out_valid), 32'h1);
    checkOutput("solo_data_0", 32'(rr_arb_out), 32'h5A);
    checkOutput("solo_id_0", 32'(rr_grant_id), 32'h2);
    checkOutput("fx_solo_grant_0", 32'(fx_grant), 32'h4);
    step();
    checkOutput("solo_grant_1", 32'(rr_grant), 32'h0);
    checkOutput("solo_valid_1", 32'(rr_out_valid), 32'h0);
    checkOutput("solo_id_1", 32'(rr_grant_id), 32'h2);
    step();
    checkOutput("solo_grant_2", 32'(rr_grant), 32'h4);
    checkOutput("solo_valid_2", 32'(rr_out_valid), 32'h1);

    // Requests stop while a word is valid
    applyStimulus(4'h0, 32'hA5A5A5A5, 1'b1);
    step();
    checkOutput("stop_valid", 32'(rr_out_valid), 32'h0);
    checkOutput("stop_grant", 32'(rr_grant), 32'h0);
    checkOutput("stop_data_hold", 32'(rr_arb_out), 32'h5A);
    checkOutput("stop_id_hold", 32'(rr_grant_id), 32'h2);
    step();
    checkOutput("idle_valid", 32'(rr_out_valid), 32'h0);
    checkOutput("idle_data_hold", 32'(rr_arb_out), 32'h5A);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule

// File: doc/arbi_rr.md
Name: arbi_rr

Overview:
- Parametrised N-channel arbiter that selects one requesting channel and forwards its data word into a single registered output stage.
- Output stage uses a valid/ready handshake.
- Selection is round-robin or fixed-priority, chosen by a parameter.
- Sits between multiple producer blocks and one shared downstream consumer.

Parameters:
- NUM_CH, 4, number of request channels; legal range 2..16.
- DATA_W, 8, width of each channel's data word and of arb_out.
- RR_MODE, 1, selection mode: 1 = round-robin, 0 = fixed priority (lowest index wins).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- req  in  NUM_CH  per-channel request; bit i is channel i.
- data_in  in  NUM_CH*DATA_W  channel i data at [i*DATA_W +: DATA_W].
- grant  out  NUM_CH  one-hot acceptance pulse; registered.
- grant_id  out  $clog2(NUM_CH)  index of the most recently accepted channel; registered.
- arb_out  out  DATA_W  data word of the accepted channel; registered.
- out_valid  out  1  arb_out holds an unconsumed word.
- out_ready  in  1  downstream consumer accepts arb_out this cycle.

Behaviour:
- Reset values (immediately on reset low, regardless of clk):
  - arb_out=0, out_valid=0, grant=0, grant_id=0.
  - Internal last-winner pointer = NUM_CH-1, so channel 0 has first priority.
- Load condition at a rising edge: load = !out_valid || out_ready.
- Eligible set = req & ~grant. A channel granted in the previous cycle is masked for one edge, so it is never captured twice on one held request.
- Round-robin mode: winner = first eligible index searching upward from pointer+1, wrapping modulo NUM_CH.
- Fixed mode: winner = lowest eligible index; the pointer is not used for selection.
- Edge with load=1 and a non-empty eligible set:
  - arb_out <= data_in[winner]; out_valid <= 1.
  - grant <= onehot(winner); grant_id <= winner; pointer <= winner.
- Edge with load=1 and an empty eligible set:
  - out_valid <= 0; grant <= 0.
  - arb_out, grant_id and pointer hold.
- Edge with load=0 (out_valid=1, out_ready=0, i.e. backpressure):
  - arb_out, out_valid, grant_id and pointer hold; grant <= 0.
  - No channel is accepted.
- Latency:
  - Request sampled at edge E appears on arb_out and grant during the cycle after E.
  - Zero-bubble throughput: one word per cycle while out_ready=1 and eligible requests exist.
- Requester protocol:
  - Hold req and data_in stable until grant[i] is seen high.
  - At the edge where grant[i]=1 is sampled, drop req or present the next word.
  - Because of the mask, one channel is accepted at most every other cycle; others fill the gap.
- grant is zero or one-hot; it is never asserted during backpressure.
- Simultaneous out_ready and new requests: the consumed word is replaced in the same edge (load=1), with no bubble.
- Requests are never dropped: a req deasserted before its grant is simply not served.
- Reset mid-operation: an in-flight arb_out word is discarded, pointer returns to NUM_CH-1, and no grant is issued until reset releases.
- Data width: arb_out is exactly DATA_W bits; no truncation or extension.

Test Plan (NUM_CH=4, DATA_W=8):
- Round-robin, all req=4'hF held, data 0x10/0x11/0x12/0x13, out_ready=1 -> arb_out sequence 0x10,0x11,0x12,0x13,0x10; grant 1,2,4,8,1; out_valid=1 throughout.
- RR_MODE=0, all req held, out_ready=1 -> arb_out alternates 0x10,0x11,0x10,0x11 (channel 0 masked every other cycle); channels 2 and 3 never granted.
- Round-robin, all req, out_ready=0 for 3 cycles after first capture -> arb_out stays 0x10, out_valid=1, grant=0 for 3 cycles; on release, next captures are 0x11 then 0x12.
- Only req[2]=1 held, data 0x5A, out_ready=1 -> grant=4'h4 every other cycle; out_valid toggles 1,0,1,0; grant_id=2.
- Requests stop: req=0 while out_valid=1, out_ready=1 -> out_valid falls next cycle; arb_out and grant_id hold their last values.
- Reset asserted mid-stream with out_valid=1, arb_out=0x12 -> all outputs 0 immediately without a clk edge; after release with req=4'hF, first grant goes to channel 0 (arb_out=0x10).
